shift_normalizer: RTL and testbench

//  Multi-cycle count-leading-zeros/ones unit: the inverse of the pipeline shifter.

---
 rtl/shift_normalizer.sv | 162 ++++++++++++++++
 tb/tb_shift_normalizer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/shift_normalizer.sv
// shift_normalizer
//   Multi-cycle count-leading-zeros / count-leading-ones unit. Finds the
//   left-shift amount that normalizes an operand using a binary search, one
//   step per clock (STEPS = log2(WIDTH) steps, data-independent latency), and
//   returns that count together with the shifted (normalized) word.
//
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset; clears all state/outputs
//   start       in   request; sampled only in IDLE or DONE
//   in          in   operand, captured on the accepted start edge
//   count_ones  in   0 = count leading zeros, 1 = count leading ones
//   busy        out  high while searching (stall request)
//   done        out  one-cycle pulse, count/normalized valid
//   count       out  leading-bit count, 0..WIDTH
//   normalized  out  in << count, zero filled; 0 when count == WIDTH
module shift_normalizer #(
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [WIDTH-1:0]         in,
  input  logic                     count_ones,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(WIDTH):0]   count,
  output logic [WIDTH-1:0]         normalized
);

  localparam int STEPS = $clog2(WIDTH);
  localparam int CW    = STEPS + 1;
  localparam int LAST  = STEPS - 1;
  localparam logic [STEPS-1:0] LAST_STEP = LAST[STEPS-1:0];
  localparam logic [CW-1:0]    WIDTH_C   = WIDTH[CW-1:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [STEPS-1:0]   step_r;
  logic [WIDTH-1:0]   work_r;
  logic [WIDTH-1:0]   norm_r;
  logic [CW-1:0]      cnt_r;
  logic               zero_r;
  logic               busy_r;
  logic               done_r;
  logic [CW-1:0]      count_r;
  logic [WIDTH-1:0]   normalized_r;

  logic               accept_s;
  logic               last_step_s;
  logic [CW-1:0]      k_s;
  logic               hit_s;
  logic [WIDTH-1:0]   operand_s;
  logic [WIDTH-1:0]   work_nxt_s;
  logic [WIDTH-1:0]   norm_nxt_s;
  logic [CW-1:0]      cnt_nxt_s;

  // True when the top k bits of w are all zero.
  function automatic logic top_clear(input logic [WIDTH-1:0] w, input logic [CW-1:0] k);
    logic [WIDTH-1:0] mask;
    mask = ~({WIDTH{1'b1}} >> k);
    return ((w & mask) == {WIDTH{1'b0}});
  endfunction

  // Handshake decode and next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = start && ((state_r == IDLE) || (state_r == DONE));
    last_step_s = (state_r == SCAN) && (step_r == LAST_STEP);
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = SCAN;
        else       state_nxt_s = IDLE;
      end
      SCAN: begin
        if (last_step_s) state_nxt_s = DONE;
        else             state_nxt_s = SCAN;
      end
      DONE: begin
        if (start) state_nxt_s = SCAN;
        else       state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One binary-search step: step size halves each cycle (WIDTH/2 ... 1).
  always_comb begin
    k_s        = WIDTH_C >> (step_r + 1'b1);
    hit_s      = top_clear(work_r, k_s);
    work_nxt_s = hit_s ? (work_r << k_s) : work_r;
    norm_nxt_s = hit_s ? (norm_r << k_s) : norm_r;
    cnt_nxt_s  = hit_s ? (cnt_r + k_s) : cnt_r;
    // CLO is searched as CLZ on the inverted operand.
    operand_s  = count_ones ? ~in : in;
  end

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Search datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_r       <= {STEPS{1'b0}};
      work_r       <= {WIDTH{1'b0}};
      norm_r       <= {WIDTH{1'b0}};
      cnt_r        <= {CW{1'b0}};
      zero_r       <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      count_r      <= {CW{1'b0}};
      normalized_r <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      step_r <= {STEPS{1'b0}};
      work_r <= operand_s;
      norm_r <= in;
      cnt_r  <= {CW{1'b0}};
      zero_r <= (operand_s == {WIDTH{1'b0}});
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (state_r == SCAN) begin
      step_r <= step_r + 1'b1;
      work_r <= work_nxt_s;
      norm_r <= norm_nxt_s;
      cnt_r  <= cnt_nxt_s;
      if (last_step_s) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
        // All-zero work never sets a bit, so the search alone would stop
        // at WIDTH-1; the captured zero flag supplies the full count.
        if (zero_r) begin
          count_r      <= WIDTH_C;
          normalized_r <= {WIDTH{1'b0}};
        end else begin
          count_r      <= cnt_nxt_s;
          normalized_r <= norm_nxt_s;
        end
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end
  end

  assign busy       = busy_r;
  assign done       = done_r;
  assign count      = count_r;
  assign normalized = normalized_r;

endmodule

// File: tb/tb_shift_normalizer.sv
module tb_shift_normalizer;

  typedef struct packed {
    logic [5:0]  c;
    logic [31:0] n;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] din;
  logic        count_ones;
  logic        busy;
  logic        done;
  logic [5:0]  count;
  logic [31:0] normalized;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   cyc;

  shift_normalizer #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .in         (din),
    .count_ones (count_ones),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .normalized (normalized)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the scoreboard head.
  always @(posedge clock) begin
    #1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got count=%0d with no pending request", count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("count", {26'd0, count}, {26'd0, e.c});
        check("normalized", normalized, e.n);
      end
    end
  end

  // Issue one request; optionally poke a second start at E2. Returns the
  // cycle number of the done pulse.
  task automatic run(input logic [31:0] v, input logic co, input logic [5:0] ec,
                     input logic [31:0] en, input bit poke, output int done_cyc);
    int cycles;
    exp_t e;
    @(negedge clock);
    din = v; count_ones = co; start = 1'b1;
    e.c = ec; e.n = en;
    sb.push_back(e);
    @(posedge clock); #1;            // E0
    start = 1'b0;
    din = ~v; count_ones = ~co;      // must not disturb the search
    check("busy_after_accept", {31'd0, busy}, 32'd1);
    cycles = 0;
    while (done !== 1'b1 && cycles < 20) begin
      @(posedge clock); #1;
      cycles++;
      if (poke && cycles == 1) begin din = 32'h0000000F; count_ones = 1'b0; start = 1'b1; end
      if (poke && cycles == 2) start = 1'b0;
    end
    done_cyc = cyc;
    check("latency", cycles, 32'd5);
    check("busy_at_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d0, d1;
    exp_t junk;
    n_cmp = 0; n_bad = 0; cyc = 0;
    reset = 1'b1; start = 1'b0; din = 32'h0; count_ones = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_count", {26'd0, count}, 32'd0);
    check("reset_norm", normalized, 32'd0);
    @(negedge clock); reset = 1'b0;

    run(32'h00010000, 1'b0, 6'd15, 32'h80000000, 1'b0, d0);
    repeat (2) @(negedge clock);
    run(32'h00000000, 1'b0, 6'd32, 32'h00000000, 1'b0, d0);
    repeat (2) @(negedge clock);
    run(32'h80000000, 1'b0, 6'd0,  32'h80000000, 1'b0, d0);
    repeat (2) @(negedge clock);
    run(32'hFFF01234, 1'b1, 6'd12, 32'h01234000, 1'b0, d0);
    repeat (2) @(negedge clock);
    run(32'hFFFFFFFF, 1'b1, 6'd32, 32'h00000000, 1'b0, d0);
    repeat (2) @(negedge clock);
    run(32'h7FFFFFFF, 1'b1, 6'd0,  32'h7FFFFFFF, 1'b0, d0);
    repeat (2) @(negedge clock);
    // Second start at E2 is ignored.
    run(32'h00000001, 1'b0, 6'd31, 32'h80000000, 1'b1, d0);
    repeat (2) @(negedge clock);

    // Reset between E2 and E3 aborts the search.
    @(negedge clock);
    din = 32'h00000100; count_ones = 1'b0; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;   // E0
    @(posedge clock);                     // E1
    @(posedge clock);                     // E2
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_count", {26'd0, count}, 32'd0);
    check("abort_norm", normalized, 32'd0);
    repeat (6) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("no_done_after_abort", {31'd0, done}, 32'd0);
    run(32'h00000100, 1'b0, 6'd23, 32'h80000000, 1'b0, d0);
    repeat (2) @(negedge clock);

    // Back-to-back: second start issued in the DONE cycle.
    run(32'h00FF0000, 1'b0, 6'd8, 32'hFF000000, 1'b0, d0);
    run(32'h7FFFFFFF, 1'b0, 6'd1, 32'hFFFFFFFE, 1'b0, d1);
    check("b2b_spacing", d1 - d0, 32'd6);

    repeat (4) @(posedge clock);
    #2;
    check("scoreboard_empty", sb.size(), 32'd0);
    while (sb.size() > 0) junk = sb.pop_front();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
